m_sequential_store: RTL and testbench



---
 rtl/m_sequential_store.sv | 224 ++++++++++++++++++++++
 tb/tb_m_sequential_store.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m_sequential_store.sv
// Matrix sequential store datapath: packs nibble entries from the deshuffle unit
// into AXI W beats framed by the transaction controller (strobes and last included).
module m_sequential_store #(
    parameter int unsigned  NrExits          = 4,
    parameter int unsigned  Dlen             = 64,
    parameter int unsigned  AxiDataWidth     = 128,
    parameter int unsigned  AxiAddrWidth     = 64,
    localparam int unsigned NrLaneEntriesNbs = Dlen / 4 * NrExits,
    localparam int unsigned BusNibbles       = AxiDataWidth / 4,
    localparam int unsigned BusNSize         = $clog2(BusNibbles),
    localparam int unsigned StrbW            = AxiDataWidth / 8
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          rx_dshfu_valid_i,
    output logic                          rx_dshfu_ready_o,
    input  logic [NrLaneEntriesNbs*4-1:0] rx_dshfu_nb_i,
    input  logic [NrLaneEntriesNbs-1:0]   rx_dshfu_en_i,
    input  logic                          txn_ctrl_valid_i,
    output logic                          txn_ctrl_ready_o,
    input  logic [AxiAddrWidth-1:0]       txn_ctrl_addr_i,
    input  logic                          txn_ctrl_is_head_i,
    input  logic                          txn_ctrl_is_final_txn_i,
    input  logic [7:0]                    txn_ctrl_rmn_beat_i,
    input  logic [BusNSize:0]             txn_ctrl_lbn_i,
    output logic                          axi_w_valid_o,
    input  logic                          axi_w_ready_i,
    output logic [AxiDataWidth-1:0]       axi_w_data_o,
    output logic [StrbW-1:0]              axi_w_strb_o,
    output logic                          axi_w_last_o
);

    localparam int unsigned MaxNbs = (NrLaneEntriesNbs > BusNibbles) ? NrLaneEntriesNbs : BusNibbles;
    localparam int unsigned CntW   = $clog2(MaxNbs + 1);
    localparam int unsigned EntW   = NrLaneEntriesNbs * 4;
    localparam int unsigned BusW   = AxiDataWidth;

    typedef enum logic {
        S_IDLE,
        S_PACK
    } state_e;

    state_e          state_reg, state_next;
    logic [CntW-1:0] bus_nb_cnt_reg, bus_nb_cnt_next;
    logic [CntW-1:0] seq_nb_ptr_reg, seq_nb_ptr_next;
    logic [BusW-1:0] build_reg, build_next;

    // Two-entry ping-pong buffer; {wrap, ptr} pairs distinguish full from empty.
    logic [EntW-1:0] buf_nb_reg [2];
    logic [CntW-1:0] buf_cnt_reg [2];
    logic            enq_ptr_reg, enq_wrap_reg;
    logic            deq_ptr_reg, deq_wrap_reg;
    logic            full, empty, enq, deq;
    logic [CntW-1:0] enq_cnt;

    logic            w_valid_reg;
    logic [BusW-1:0] w_data_reg;
    logic [StrbW-1:0] w_strb_reg;
    logic            w_last_reg;

    logic [EntW-1:0] head_nb;
    logic [CntW-1:0] head_cnt;
    logic [CntW-1:0] lower, upper, bus_rmn, seq_rmn, step_n, dst_off;
    logic            is_last, is_final_beat;
    logic            beat_done, seq_done;
    logic            pack_req, out_free, step_exec, beat_load;
    logic [BusW-1:0] src_low, step_mask, placed, beat_data;
    logic [StrbW-1:0] beat_strb;
    logic            unused_addr_bits;

    assign unused_addr_bits = ^txn_ctrl_addr_i[AxiAddrWidth-1:BusNSize];

    assign full  = (enq_ptr_reg == deq_ptr_reg) && (enq_wrap_reg != deq_wrap_reg);
    assign empty = (enq_ptr_reg == deq_ptr_reg) && (enq_wrap_reg == deq_wrap_reg);
    assign rx_dshfu_ready_o = !full;
    assign enq = rx_dshfu_valid_i && !full;

    // Enables are a thermometer, so the popcount is the entry length.
    always_comb begin
        enq_cnt = '0;
        for (int i = 0; i < NrLaneEntriesNbs; i++) begin
            enq_cnt = enq_cnt + CntW'(rx_dshfu_en_i[i]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq) begin
            buf_nb_reg[enq_ptr_reg]  <= rx_dshfu_nb_i;
            buf_cnt_reg[enq_ptr_reg] <= enq_cnt;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            enq_ptr_reg  <= 1'b0;
            enq_wrap_reg <= 1'b0;
            deq_ptr_reg  <= 1'b0;
            deq_wrap_reg <= 1'b0;
        end else begin
            if (enq) begin
                {enq_wrap_reg, enq_ptr_reg} <= {enq_wrap_reg, enq_ptr_reg} + 2'd1;
            end
            if (deq) begin
                {deq_wrap_reg, deq_ptr_reg} <= {deq_wrap_reg, deq_ptr_reg} + 2'd1;
            end
        end
    end

    assign head_nb  = buf_nb_reg[deq_ptr_reg];
    assign head_cnt = buf_cnt_reg[deq_ptr_reg];

    // Nibble window of the current beat and the size of this pack step.
    assign is_last       = (txn_ctrl_rmn_beat_i == 8'd0);
    assign is_final_beat = is_last && txn_ctrl_is_final_txn_i;
    assign lower   = txn_ctrl_is_head_i ? CntW'(txn_ctrl_addr_i[BusNSize-1:0]) : '0;
    assign upper   = is_last ? CntW'(txn_ctrl_lbn_i) : CntW'(BusNibbles);
    assign bus_rmn = upper - lower - bus_nb_cnt_reg;
    assign seq_rmn = head_cnt - seq_nb_ptr_reg;
    assign step_n  = (bus_rmn < seq_rmn) ? bus_rmn : seq_rmn;
    assign dst_off = lower + bus_nb_cnt_reg;

    assign beat_done = (step_n == bus_rmn);
    assign seq_done  = (step_n == seq_rmn);
    assign pack_req  = (state_reg == S_PACK) && txn_ctrl_valid_i && !empty;
    assign out_free  = !w_valid_reg || axi_w_ready_i;
    // A completing step needs the output register; a partial step never stalls.
    assign step_exec = pack_req && (!beat_done || out_free);
    assign beat_load = step_exec && beat_done;
    assign deq       = step_exec && (seq_done || (beat_done && is_final_beat));

    assign txn_ctrl_ready_o = beat_load;

    assign src_low = BusW'(head_nb >> {seq_nb_ptr_reg, 2'b00});

    for (genvar gi = 0; gi < BusNibbles; gi++) begin : g_step_mask
        assign step_mask[gi*4 +: 4] = {4{CntW'(gi) < step_n}};
    end

    for (genvar gi = 0; gi < StrbW; gi++) begin : g_strb
        assign beat_strb[gi] = (CntW'(2 * gi) >= lower) && (CntW'(2 * gi + 1) < upper);
    end

    assign placed    = (src_low & step_mask) << {dst_off, 2'b00};
    assign beat_data = build_reg | placed;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg      <= S_IDLE;
            bus_nb_cnt_reg <= '0;
            seq_nb_ptr_reg <= '0;
            build_reg      <= '0;
        end else begin
            state_reg      <= state_next;
            bus_nb_cnt_reg <= bus_nb_cnt_next;
            seq_nb_ptr_reg <= seq_nb_ptr_next;
            build_reg      <= build_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        bus_nb_cnt_next = bus_nb_cnt_reg;
        seq_nb_ptr_next = seq_nb_ptr_reg;
        build_next      = build_reg;
        case (state_reg)
            S_IDLE: begin
                if (txn_ctrl_valid_i) begin
                    state_next      = S_PACK;
                    bus_nb_cnt_next = '0;
                    seq_nb_ptr_next = '0;
                    build_next      = '0;
                end
            end
            S_PACK: begin
                if (step_exec) begin
                    seq_nb_ptr_next = deq ? '0 : seq_nb_ptr_reg + step_n;
                    if (beat_done) begin
                        bus_nb_cnt_next = '0;
                        build_next      = '0;
                        if (is_final_beat) begin
                            state_next = S_IDLE;
                        end
                    end else begin
                        bus_nb_cnt_next = bus_nb_cnt_reg + step_n;
                        build_next      = beat_data;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            w_valid_reg <= 1'b0;
            w_data_reg  <= '0;
            w_strb_reg  <= '0;
            w_last_reg  <= 1'b0;
        end else if (beat_load) begin
            w_valid_reg <= 1'b1;
            w_data_reg  <= beat_data;
            w_strb_reg  <= beat_strb;
            w_last_reg  <= is_last;
        end else if (axi_w_ready_i) begin
            w_valid_reg <= 1'b0;
        end
    end

    assign axi_w_valid_o = w_valid_reg;
    assign axi_w_data_o  = w_data_reg;
    assign axi_w_strb_o  = w_strb_reg;
    assign axi_w_last_o  = w_last_reg;

    a_window_even: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_reg == S_PACK && txn_ctrl_valid_i) |-> (!lower[0] && !upper[0]));

    a_step_widths: assert property (@(posedge clk_i) disable iff (!rst_ni)
        pack_req |-> ((bus_rmn <= CntW'(BusNibbles)) && (seq_rmn <= CntW'(NrLaneEntriesNbs))));

    // A request must end exactly on an entry boundary.
    a_no_leftover: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (beat_load && is_final_beat) |-> seq_done);

endmodule

// File: tb/tb_m_sequential_store.sv
// Randomized bench for m_sequential_store: a stream-level model lays entry nibbles
// into beat windows in order and the monitor compares every W beat against it.
module tb_m_sequential_store;

    localparam int BN = 32;

    logic         clk = 1'b0;
    logic         rst_ni;
    logic         rx_valid;
    logic         rx_ready;
    logic [255:0] rx_nb;
    logic [63:0]  rx_en;
    logic         txn_valid;
    logic         txn_ready;
    logic [63:0]  txn_addr;
    logic         txn_head;
    logic         txn_final;
    logic [7:0]   txn_rmn;
    logic [5:0]   txn_lbn;
    logic         w_valid;
    logic         w_ready;
    logic [127:0] w_data;
    logic [15:0]  w_strb;
    logic         w_last;

    always #5 clk = ~clk;

    m_sequential_store dut (
        .clk_i                   (clk),
        .rst_ni                  (rst_ni),
        .rx_dshfu_valid_i        (rx_valid),
        .rx_dshfu_ready_o        (rx_ready),
        .rx_dshfu_nb_i           (rx_nb),
        .rx_dshfu_en_i           (rx_en),
        .txn_ctrl_valid_i        (txn_valid),
        .txn_ctrl_ready_o        (txn_ready),
        .txn_ctrl_addr_i         (txn_addr),
        .txn_ctrl_is_head_i      (txn_head),
        .txn_ctrl_is_final_txn_i (txn_final),
        .txn_ctrl_rmn_beat_i     (txn_rmn),
        .txn_ctrl_lbn_i          (txn_lbn),
        .axi_w_valid_o           (w_valid),
        .axi_w_ready_i           (w_ready),
        .axi_w_data_o            (w_data),
        .axi_w_strb_o            (w_strb),
        .axi_w_last_o            (w_last)
    );

    typedef struct packed {
        logic [63:0] addr;
        logic        head;
        logic        fin;
        logic [7:0]  rmn;
        logic [5:0]  lbn;
    } desc_t;

    typedef struct packed {
        logic [127:0] data;
        logic [15:0]  strb;
        logic         last;
    } beat_t;

    desc_t        desc_q[$];
    logic [255:0] ent_nb_q[$];
    logic [63:0]  ent_en_q[$];
    beat_t        exp_q[$];
    int           win_lo[$];
    int           win_up[$];
    bit           win_last[$];

    int checks = 0;
    int errors = 0;
    int beats_seen = 0;
    bit abort = 1'b0;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // One transaction of nbeats beats; windows are remembered until the request closes.
    task automatic add_txn(input int nbeats, input int low, input int lbn, input bit fin);
        desc_t d;
        for (int b = 0; b < nbeats; b++) begin
            d.addr      = {$urandom, $urandom};
            d.addr[4:0] = 5'(low);
            d.head      = (b == 0);
            d.fin       = fin;
            d.rmn       = 8'(nbeats - 1 - b);
            d.lbn       = 6'(lbn);
            desc_q.push_back(d);
            win_lo.push_back(b == 0 ? low : 0);
            win_up.push_back(b == nbeats - 1 ? lbn : BN);
            win_last.push_back(b == nbeats - 1);
        end
    endtask

    // Cut the request's nibble total into entries and lay the stream into the windows.
    task automatic close_request(input int fixed_cnt, input bit pattern);
        int           total;
        int           c;
        logic [255:0] nb;
        logic [63:0]  en;
        logic [3:0]   stream[$];
        beat_t        bt;
        total = 0;
        foreach (win_lo[w]) total += win_up[w] - win_lo[w];
        while (total > 0) begin
            c = (fixed_cnt > 0) ? fixed_cnt : int'($urandom_range(64, 1));
            if (c > total) c = total;
            en = '0;
            for (int k = 0; k < 64; k++) begin
                nb[k*4 +: 4] = pattern ? 4'(k) : 4'($urandom);
                if (k < c) begin
                    en[k] = 1'b1;
                    stream.push_back(nb[k*4 +: 4]);
                end
            end
            ent_nb_q.push_back(nb);
            ent_en_q.push_back(en);
            total -= c;
        end
        foreach (win_lo[w]) begin
            bt.data = '0;
            bt.strb = '0;
            for (int i = win_lo[w]; i < win_up[w]; i++) bt.data[i*4 +: 4] = stream.pop_front();
            for (int i = 0; i < 16; i++) bt.strb[i] = (2 * i >= win_lo[w]) && (2 * i + 1 < win_up[w]);
            bt.last = win_last[w];
            exp_q.push_back(bt);
        end
        win_lo.delete();
        win_up.delete();
        win_last.delete();
    endtask

    task automatic add_random_request();
        int ntxn, nb, low, lbn;
        ntxn = $urandom_range(2, 1);
        for (int t = 0; t < ntxn; t++) begin
            nb  = $urandom_range(4, 1);
            low = 2 * $urandom_range(15, 0);
            if (nb == 1) lbn = 2 * $urandom_range(16, low / 2 + 1);
            else         lbn = 2 * $urandom_range(16, 1);
            add_txn(nb, low, lbn, t == ntxn - 1);
        end
        close_request(0, 1'b0);
    endtask

    task automatic drive_entries(input int gap_pct, input int budget);
        bit fire;
        for (int cyc = 0; cyc < budget && ent_nb_q.size() > 0 && !abort; cyc++) begin
            if (!rx_valid && $urandom_range(99) >= gap_pct) begin
                rx_valid = 1'b1;
                rx_nb    = ent_nb_q[0];
                rx_en    = ent_en_q[0];
            end
            @(negedge clk);
            fire = rx_valid && rx_ready;
            @(posedge clk);
            #1;
            if (fire) begin
                ent_nb_q.delete(0);
                ent_en_q.delete(0);
                rx_valid = 1'b0;
            end
        end
        rx_valid = 1'b0;
    endtask

    task automatic drive_desc(input int gap_pct, input int budget);
        bit fire;
        for (int cyc = 0; cyc < budget && desc_q.size() > 0 && !abort; cyc++) begin
            if (!txn_valid && $urandom_range(99) >= gap_pct) begin
                txn_valid = 1'b1;
                txn_addr  = desc_q[0].addr;
                txn_head  = desc_q[0].head;
                txn_final = desc_q[0].fin;
                txn_rmn   = desc_q[0].rmn;
                txn_lbn   = desc_q[0].lbn;
            end
            @(negedge clk);
            fire = txn_valid && txn_ready;
            @(posedge clk);
            #1;
            if (fire) begin
                desc_q.delete(0);
                txn_valid = 1'b0;
            end
        end
        txn_valid = 1'b0;
    endtask

    // hold_len > 0 forces ready low for that many cycles from the first valid beat.
    task automatic monitor_w(input int ready_pct, input int hold_len, input int budget);
        bit           stalled = 1'b0;
        bit           hold_done = 1'b0;
        int           hold = 0;
        int           cyc = 0;
        logic [127:0] pd;
        logic [15:0]  ps;
        logic         pl;
        beat_t        e;
        while (exp_q.size() > 0 && !abort && cyc < budget) begin
            if (hold_len > 0 && !hold_done && w_valid) begin
                hold      = hold_len;
                hold_done = 1'b1;
            end
            w_ready = (hold > 0) ? 1'b0 : ($urandom_range(99) < ready_pct);
            @(negedge clk);
            if (stalled) begin
                check_val("hold_valid", w_valid, 1'b1);
                check_val("hold_data", w_data, pd);
                check_val("hold_strb", w_strb, ps);
                check_val("hold_last", w_last, pl);
            end
            if (hold == 2) begin
                check_val("bp_rx_ready", rx_ready, 1'b0);
                check_val("bp_txn_ready", txn_ready, 1'b0);
            end
            if (w_valid && w_ready) begin
                e = exp_q.pop_front();
                $display("beat %0d data %h strb %h last %0d", beats_seen, w_data, w_strb, w_last);
                check_val("beat_data", w_data, e.data);
                check_val("beat_strb", w_strb, e.strb);
                check_val("beat_last", w_last, e.last);
                beats_seen++;
            end
            stalled = w_valid && !w_ready;
            pd = w_data;
            ps = w_strb;
            pl = w_last;
            @(posedge clk);
            #1;
            if (hold > 0) hold--;
            cyc++;
        end
        if (!abort) check_val("beats_left", exp_q.size(), 0);
        w_ready = 1'b1;
    endtask

    task automatic run_phase(input int ready_pct, input int gap_pct, input int hold_len, input int budget);
        fork
            drive_entries(gap_pct, budget);
            drive_desc(gap_pct, budget);
            monitor_w(ready_pct, hold_len, budget);
        join
    endtask

    task automatic settle(input string tag);
        repeat (2) @(posedge clk);
        #1;
        check_val({tag, "_w_valid_idle"}, w_valid, 1'b0);
        check_val({tag, "_txn_ready_idle"}, txn_ready, 1'b0);
        check_val({tag, "_rx_ready"}, rx_ready, 1'b1);
        check_val({tag, "_desc_left"}, desc_q.size(), 0);
        check_val({tag, "_ent_left"}, ent_nb_q.size(), 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni    = 1'b0;
        rx_valid  = 1'b0;
        rx_nb     = '0;
        rx_en     = '0;
        txn_valid = 1'b0;
        txn_addr  = '0;
        txn_head  = 1'b0;
        txn_final = 1'b0;
        txn_rmn   = '0;
        txn_lbn   = '0;
        w_ready   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_w_valid", w_valid, 1'b0);
        check_val("rst_w_data", w_data, 0);
        check_val("rst_w_strb", w_strb, 0);
        check_val("rst_w_last", w_last, 1'b0);
        check_val("rst_txn_ready", txn_ready, 1'b0);
        check_val("rst_rx_ready", rx_ready, 1'b1);
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;

        // Aligned two-beat store of one full 64-nibble entry.
        add_txn(2, 0, 32, 1'b1);
        close_request(64, 1'b1);
        run_phase(100, 0, 0, 2000);
        settle("aligned");

        // Misaligned single beat, 16-nibble entry.
        add_txn(1, 8, 24, 1'b1);
        close_request(64, 1'b1);
        run_phase(100, 0, 0, 2000);
        settle("misaligned");

        // One entry spread over three beats.
        add_txn(3, 8, 8, 1'b1);
        close_request(64, 1'b1);
        run_phase(100, 0, 0, 2000);
        settle("span3");

        // W backpressure during a four-beat txn fed by four 32-nibble entries.
        add_txn(4, 0, 32, 1'b1);
        close_request(32, 1'b0);
        run_phase(100, 0, 5, 2000);
        settle("backpressure");

        repeat (30) add_random_request();
        run_phase(70, 30, 0, 20000);
        settle("random_a");

        repeat (20) add_random_request();
        run_phase(30, 10, 0, 20000);
        settle("random_b");

        // Reset after the first of three beats has been accepted.
        add_txn(3, 0, 32, 1'b1);
        close_request(32, 1'b0);
        beats_seen = 0;
        fork
            run_phase(100, 0, 0, 2000);
            begin
                for (int i = 0; i < 2000 && beats_seen < 1; i++) @(posedge clk);
                check_val("rst_mid_first_beat", beats_seen, 1);
                #2;
                rst_ni = 1'b0;
                abort  = 1'b1;
                #1;
                check_val("rst_mid_w_valid", w_valid, 1'b0);
                check_val("rst_mid_w_data", w_data, 0);
                check_val("rst_mid_w_strb", w_strb, 0);
                check_val("rst_mid_w_last", w_last, 1'b0);
                check_val("rst_mid_txn_ready", txn_ready, 1'b0);
            end
        join
        desc_q.delete();
        ent_nb_q.delete();
        ent_en_q.delete();
        exp_q.delete();
        rx_valid  = 1'b0;
        txn_valid = 1'b0;
        abort     = 1'b0;
        #1;
        check_val("rst_mid_rx_ready", rx_ready, 1'b1);
        @(negedge clk);
        rst_ni = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("post_rst_no_beat", w_valid, 1'b0);
        end
        @(posedge clk);
        #1;
        add_txn(1, 4, 20, 1'b1);
        close_request(0, 1'b0);
        run_phase(100, 0, 0, 2000);
        settle("post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
